templatized_alu_exec: RTL and testbench

//  Execution end of the ALU control path. Accepts {op_code, en, a, b} with a valid/ready handshake,

---
 rtl/templatized_alu_pkg.sv | 28 ++
 rtl/templatized_alu_exec_shift_step.sv | 23 ++
 rtl/templatized_alu_exec.sv | 114 +++++++++++
 tb/tb_templatized_alu_exec.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/templatized_alu_pkg.sv
// Shared ALU control-path definitions: opcodes, group enables, exec FSM states
// and the opcode-to-group decode also used by templatized_alu_control.
package templatized_alu_pkg;

    localparam logic [2:0] OPCODE_XOR = 3'b000;
    localparam logic [2:0] OPCODE_SLL = 3'b001;
    localparam logic [2:0] OPCODE_SAR = 3'b010;
    localparam logic [2:0] OPCODE_ROL = 3'b011;
    localparam logic [2:0] OPCODE_ROR = 3'b100;

    localparam logic [1:0] EN_XOR   = 2'b10;
    localparam logic [1:0] EN_SHIFT = 2'b01;
    localparam logic [1:0] EN_NONE  = 2'b00;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    // Illegal opcodes map to EN_NONE, which no legal en value matches.
    function automatic logic [1:0] op_group(input logic [2:0] op);
        logic [1:0] grp;
        case (op)
            OPCODE_XOR:                                     grp = EN_XOR;
            OPCODE_SLL, OPCODE_SAR, OPCODE_ROL, OPCODE_ROR: grp = EN_SHIFT;
            default:                                        grp = EN_NONE;
        endcase
        op_group = grp;
    endfunction

endpackage

// File: rtl/templatized_alu_exec_shift_step.sv
// One-bit-position shift/rotate of w selected by op; non-shift ops pass w through.
module templatized_alu_shift_step
    import templatized_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] w,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = w;
        case (op)
            OPCODE_SLL: y = {w[WIDTH-2:0], 1'b0};
            OPCODE_SAR: y = {w[WIDTH-1], w[WIDTH-1:1]};
            OPCODE_ROL: y = {w[WIDTH-2:0], w[WIDTH-1]};
            OPCODE_ROR: y = {w[0], w[WIDTH-1:1]};
            default:    y = w;
        endcase
    end

endmodule

// File: rtl/templatized_alu_exec.sv
// ALU execution end: validates en against the opcode group, does XOR in one
// cycle and shift/rotate iteratively one bit per cycle, with valid/ready on both sides.
module templatized_alu_exec
    import templatized_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_code,
    input  logic [1:0]       en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [SHAMT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     step_w;
    logic [SHAMT_W-1:0]   amt;
    logic [1:0]           grp;
    logic                 accept;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign err       = err_q;
    assign accept    = in_valid && in_ready;
    // Amounts >= WIDTH wrap by plain truncation.
    assign amt       = b[SHAMT_W-1:0];
    assign grp       = op_group(op_code);

    templatized_alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .w  (work_q),
        .op (op_q),
        .y  (step_w)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        work_d   = work_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d = op_code;
                    if (grp == EN_NONE || en != grp) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else if (grp == EN_XOR) begin
                        result_d = a ^ b;
                        err_d    = 1'b0;
                        state_d  = DONE;
                    end else if (amt == '0) begin
                        result_d = a;
                        err_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        work_d  = a;
                        count_d = amt;
                        err_d   = 1'b0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d  = step_w;
                count_d = count_q - 1'b1;
                // The last step goes straight into result so DONE follows the n-th edge.
                if (count_q == SHAMT_W'(1)) begin
                    result_d = step_w;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OPCODE_XOR;
            count_q  <= '0;
            work_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            work_q   <= work_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_templatized_alu_exec.sv
// Directed + small random bench for templatized_alu_exec (WIDTH=8) with a
// queue scoreboard of expected result/err/latency.
module tb_templatized_alu_exec;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op_code = '0;
    logic [1:0] en = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       err;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    templatized_alu_exec #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .en        (en),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: whole-word shifts instead of bit-serial steps.
    function automatic exp_t model(input logic [2:0] op, input logic [1:0] e,
                                   input logic [7:0] va, input logic [7:0] vb);
        exp_t        r;
        int          n;
        logic [15:0] dbl;
        logic [15:0] rol;
        logic [15:0] ror;
        n   = int'(vb[2:0]);
        dbl = {va, va};
        rol = dbl << n;
        ror = dbl >> n;
        r.res = 8'h00;
        r.err = 1'b0;
        r.lat = 0;
        if (op == 3'd0 && e == 2'b10) begin
            r.res = va ^ vb;
        end else if (op >= 3'd1 && op <= 3'd4 && e == 2'b01) begin
            r.lat = n;
            case (op)
                3'd1:    r.res = va << n;
                3'd2:    r.res = 8'($signed(va) >>> n);
                3'd3:    r.res = rol[15:8];
                default: r.res = ror[7:0];
            endcase
        end else begin
            r.err = 1'b1;
        end
        model = r;
    endfunction

    task automatic send(input logic [2:0] op, input logic [1:0] e,
                        input logic [7:0] va, input logic [7:0] vb);
        int c = 0;
        while (!in_ready && c < 50) begin
            tick();
            c++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        op_code  = op;
        en       = e;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_code  = $urandom_range(7, 0);
        a        = $urandom_range(255, 0);
        b        = $urandom_range(255, 0);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("out_valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic pop_release(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        x = sb.pop_front();
        check({tag, "_result"}, {24'd0, result}, {24'd0, x.res});
        check({tag, "_err"}, {31'd0, err}, {31'd0, x.err});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_clr"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [1:0] e,
                         input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] xres, input logic xerr, input int xlat);
        exp_t x;
        int   cyc;
        x.res = xres;
        x.err = xerr;
        x.lat = xlat;
        sb.push_back(x);
        send(op, e, va, vb);
        wait_out(cyc);
        check({tag, "_lat"}, cyc, xlat);
        pop_release(tag);
    endtask

    initial begin
        exp_t x;
        int   cyc;
        logic [7:0] hold_res;

        // Reset state
        out_ready = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        out_ready = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Directed ops from the block's test list
        do_op("xor",    3'b000, 2'b10, 8'hA5, 8'h0F, 8'hAA, 1'b0, 0);
        do_op("sll",    3'b001, 2'b01, 8'h81, 8'h03, 8'h08, 1'b0, 3);
        do_op("sar",    3'b010, 2'b01, 8'h90, 8'h02, 8'hE4, 1'b0, 2);
        do_op("rol",    3'b011, 2'b01, 8'h81, 8'h01, 8'h03, 1'b0, 1);
        do_op("ror",    3'b100, 2'b01, 8'h81, 8'h04, 8'h18, 1'b0, 4);
        do_op("rolwrap",3'b011, 2'b01, 8'h3C, 8'h08, 8'h3C, 1'b0, 0);
        do_op("sll7",   3'b001, 2'b01, 8'hFF, 8'h07, 8'h80, 1'b0, 7);
        do_op("err101", 3'b101, 2'b00, 8'h55, 8'h33, 8'h00, 1'b1, 0);
        do_op("errgrp", 3'b000, 2'b01, 8'h55, 8'h33, 8'h00, 1'b1, 0);
        do_op("erren11",3'b001, 2'b11, 8'h55, 8'h02, 8'h00, 1'b1, 0);

        // Backpressure: out_ready low for 5 cycles while junk is offered
        x.res = 8'h26; x.err = 1'b0; x.lat = 0;
        sb.push_back(x);
        send(3'b000, 2'b10, 8'h12, 8'h34);
        wait_out(cyc);
        hold_res = result;
        check("bp_first", {24'd0, hold_res}, 32'h26);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op_code  = 3'b000;
            en       = 2'b10;
            a        = 8'hFF;
            b        = 8'h00;
            tick();
            check("bp_result", {24'd0, result}, {24'd0, hold_res});
            check("bp_err", {31'd0, err}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        pop_release("bp");
        do_op("bp_next", 3'b100, 2'b01, 8'h01, 8'h01, 8'h80, 1'b0, 1);

        // Reset in the middle of a long shift drops the op
        send(3'b001, 2'b01, 8'h01, 8'h07);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_ready_back", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        do_op("after_rst", 3'b000, 2'b10, 8'hC3, 8'h3C, 8'hFF, 1'b0, 0);

        // Random ops against the reference model
        for (int i = 0; i < 12; i++) begin
            logic [2:0] rop;
            logic [1:0] ren;
            logic [7:0] ra, rb;
            rop = $urandom_range(4, 0);
            if (i % 4 == 3) rop = $urandom_range(7, 0);
            ren = (rop == 3'd0) ? 2'b10 : 2'b01;
            if (i % 5 == 4) ren = $urandom_range(3, 0);
            ra = $urandom_range(255, 0);
            rb = $urandom_range(255, 0);
            x = model(rop, ren, ra, rb);
            do_op("rand", rop, ren, ra, rb, x.res, x.err, x.lat);
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
